// File: rtl/ad7908_pkg.sv
// rtl/ad7908_pkg.sv - shared constants and types for the AD7908 SPI responder
//
// Purpose: control-word bit positions, frame length, FSM state encoding and
//          the helper that builds the 16-bit DOUT word.
// Ports:   none (package).
package ad7908_pkg;

    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = 5;

    // Received control word, MSB first:
    // WRITE SEQ DC ADD2 ADD1 ADD0 PM1 PM0 SHADOW WEAK RANGE CODING x x x x
    // Only the fields the responder acts on are named here.
    localparam int WRITE_BIT  = 15;
    localparam int ADD_MSB    = 12;
    localparam int ADD_LSB    = 10;
    localparam int RANGE_BIT  = 5;
    localparam int CODING_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // DOUT word: leading zero, channel address, 8 data bits, 4 trailing zeros.
    // Twos-complement coding (coding = 0) is offset binary with the MSB flipped.
    function automatic logic [15:0] build_out_word(
        input logic [2:0] addr,
        input logic [7:0] data,
        input logic       coding
    );
        logic [7:0] coded;
        coded = coding ? data : (data ^ 8'h80);
        return {1'b0, addr, coded, 4'b0000};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - synchronizers and edge pulses for the SPI pins
//
// Purpose: brings spi_sck / spi_cs_n / spi_mosi into the clk domain through
//          SYNC_STAGES flops and produces one-cycle edge pulses.
// Ports:   clk, rst      - system clock, synchronous active-high reset
//          sck_in        - raw SPI clock
//          cs_n_in       - raw frame select (active low)
//          mosi_in       - raw DIN
//          mosi_s        - synchronized DIN, aligned with sck_fall
//          sck_fall      - synchronized SCK falling edge pulse
//          cs_fall       - synchronized cs_n falling edge pulse
//          cs_rise       - synchronized cs_n rising edge pulse
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_in,
    input  logic cs_n_in,
    input  logic mosi_in,
    output logic mosi_s,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q,  sck_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    // Fills with ones after reset; edges are only reported once the chain
    // and the previous-value flop both hold real pin samples. This keeps the
    // reset value of the chains from looking like a pin edge (e.g. cs_n held
    // low across reset must not start a frame).
    logic [SYNC_STAGES:0]   valid_q,     valid_d;

    logic sck_s;
    logic cs_s;
    logic armed;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign armed  = valid_q[SYNC_STAGES];

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        valid_d     = {valid_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            valid_q     <= '0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            valid_q     <= valid_d;
        end
    end

    assign sck_fall = armed &  sck_prev_q & ~sck_s;
    assign cs_fall  = armed &  cs_prev_q  & ~cs_s;
    assign cs_rise  = armed & ~cs_prev_q  &  cs_s;

endmodule

// File: rtl/ad7908_spi_responder.sv
// rtl/ad7908_spi_responder.sv - AD7908-style SPI ADC responder
//
// Purpose: behaves as an AD7908 on the SPI bus. Each 16-SCK frame returns
//          the sample of the channel addressed by the previous write and
//          captures a new control word from DIN.
// Ports:   clk, rst         - system clock, synchronous active-high reset
//          spi_sck          - SPI clock from master (asynchronous)
//          spi_cs_n         - frame select from master, active low
//          spi_mosi         - DIN from master
//          spi_miso         - DOUT to master
//          ch_data[63:0]    - eight 8-bit samples, channel n at [8n+7:8n]
//          cfg_addr[2:0]    - channel address from the last write frame
//          cfg_range        - RANGE bit from the last write frame
//          cfg_coding       - CODING bit from the last write frame
//          frame_done       - one-cycle pulse on the 16th falling SCK edge
//          frame_abort      - one-cycle pulse when cs_n rises mid-frame
module ad7908_spi_responder
    import ad7908_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [63:0] ch_data,
    output logic [2:0]  cfg_addr,
    output logic        cfg_range,
    output logic        cfg_coding,
    output logic        frame_done,
    output logic        frame_abort
);

    logic mosi_s;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .sck_in   (spi_sck),
        .cs_n_in  (spi_cs_n),
        .mosi_in  (spi_mosi),
        .mosi_s   (mosi_s),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [15:0]      out_q,         out_d;
    // Bits already received; with the bit arriving on the current edge they
    // form the full 16-bit input shift register.
    logic [14:0]      rx_q,          rx_d;
    logic [2:0]       cfg_addr_q,    cfg_addr_d;
    logic             cfg_range_q,   cfg_range_d;
    logic             cfg_coding_q,  cfg_coding_d;
    logic             frame_done_q,  frame_done_d;
    logic             frame_abort_q, frame_abort_d;

    logic [15:0] rx_word;
    logic [7:0]  sel_data;

    assign rx_word  = {rx_q, mosi_s};
    assign sel_data = ch_data[{cfg_addr_q, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        rx_d          = rx_q;
        cfg_addr_d    = cfg_addr_q;
        cfg_range_d   = cfg_range_q;
        cfg_coding_d  = cfg_coding_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d = '0;
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    rx_d    = '0;
                    out_d   = build_out_word(cfg_addr_q, sel_data, cfg_coding_q);
                end
            end

            ST_SHIFT: begin
                // cs_n checked first so it wins over an SCK edge in the same cycle.
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    rx_d          = '0;
                    out_d         = '0;
                    frame_abort_d = 1'b1;
                end else if (sck_fall) begin
                    rx_d  = rx_word[14:0];
                    cnt_d = cnt_q + 1'b1;
                    out_d = {out_q[14:0], 1'b0};
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d      = ST_HOLD;
                        out_d        = '0;
                        frame_done_d = 1'b1;
                        if (rx_word[WRITE_BIT]) begin
                            cfg_addr_d   = rx_word[ADD_MSB:ADD_LSB];
                            cfg_range_d  = rx_word[RANGE_BIT];
                            cfg_coding_d = rx_word[CODING_BIT];
                        end
                    end
                end
            end

            ST_HOLD: begin
                // Count stays at FRAME_LEN and extra SCK edges are ignored.
                out_d = '0;
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rx_d    = '0;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            out_q         <= '0;
            rx_q          <= '0;
            cfg_addr_q    <= 3'd0;
            cfg_range_q   <= 1'b0;
            cfg_coding_q  <= 1'b1;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            rx_q          <= rx_d;
            cfg_addr_q    <= cfg_addr_d;
            cfg_range_q   <= cfg_range_d;
            cfg_coding_q  <= cfg_coding_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign spi_miso    = out_q[15];
    assign cfg_addr    = cfg_addr_q;
    assign cfg_range   = cfg_range_q;
    assign cfg_coding  = cfg_coding_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule
